// File: rtl/pulse_swallow_counter.sv
// P/S counter for the fractional-N divider. It frames P prescaler cycles, holds the
// prescaler at N+1 for the first S of them, and emits the divided clock and a ratio-load strobe.
module pulse_swallow_counter #(
  parameter int P_WIDTH = 5,
  parameter int S_WIDTH = 3,
  parameter int P_MIN   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [P_WIDTH-1:0] Pi,
  input  logic [S_WIDTH-1:0] Si,
  output logic               mc,
  output logic               div_out,
  output logic               load,
  output logic               clamp
);

  localparam int CW = (P_WIDTH > S_WIDTH) ? P_WIDTH : S_WIDTH;
  localparam logic [P_WIDTH-1:0] PMIN_V = P_WIDTH'(P_MIN);
  localparam logic [P_WIDTH-1:0] ONE    = P_WIDTH'(1);

  logic [P_WIDTH-1:0] k;
  logic [P_WIDTH-1:0] p_lat;
  logic [P_WIDTH-1:0] s_lat;
  logic [P_WIDTH-1:0] h_lat;

  logic [P_WIDTH-1:0] k_inc;
  logic [P_WIDTH-1:0] p_eff;
  logic [P_WIDTH-1:0] s_eff;
  logic [CW-1:0]      si_wide;
  logic [CW-1:0]      peff_wide;
  logic               frame_end;
  logic               pi_low;
  logic               si_high;

  // S is compared at the wider of the two widths so neither operand is truncated
  always_comb begin
    k_inc     = k + ONE;
    frame_end = (k == (p_lat - ONE));
    pi_low    = (Pi < PMIN_V);
    p_eff     = pi_low ? PMIN_V : Pi;
    si_wide   = CW'(Si);
    peff_wide = CW'(p_eff);
    si_high   = (si_wide > peff_wide);
    s_eff     = si_high ? p_eff : P_WIDTH'(si_wide);
  end

  // p_lat resets to 1 so the first released edge is already a frame end and loads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k       <= '0;
      p_lat   <= ONE;
      s_lat   <= '0;
      h_lat   <= ONE;
      mc      <= 1'b0;
      div_out <= 1'b0;
      load    <= 1'b0;
      clamp   <= 1'b0;
    end else if (frame_end) begin
      k       <= '0;
      p_lat   <= p_eff;
      s_lat   <= s_eff;
      h_lat   <= p_eff >> 1;
      mc      <= (s_eff != '0);
      div_out <= 1'b1;
      load    <= 1'b1;
      clamp   <= pi_low | si_high;
    end else begin
      k       <= k_inc;
      mc      <= (k_inc < s_lat);
      div_out <= (k_inc < h_lat);
      load    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_swallow_counter.sv
// Scoreboard bench for pulse_swallow_counter: a frame-position model predicts every cycle's
// outputs and the VCO-cycle count of each completed frame.
module tb_pulse_swallow_counter;

  localparam int PW   = 5;
  localparam int SW   = 3;
  localparam int PMIN = 2;
  localparam int N    = 1 << SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] Pi = '0;
  logic [SW-1:0] Si = '0;
  logic          mc, div_out, load, clamp;

  int numChecks = 0;
  int numFails  = 0;

  logic [3:0] expQ[$];
  int         vcoQ[$];

  int mPos = 0, mP = 1, mS = 0, mH = 1;
  bit mClamp = 1'b0;
  int vcoAcc = 0;
  bit vcoValid = 1'b0;

  always #5 clk = ~clk;

  pulse_swallow_counter #(.P_WIDTH(PW), .S_WIDTH(SW), .P_MIN(PMIN)) dut (
    .clk(clk), .rst_n(rst_n), .Pi(Pi), .Si(Si),
    .mc(mc), .div_out(div_out), .load(load), .clamp(clamp)
  );

  task automatic checkOutput(input string tag, input int obs, input int exp);
    numChecks++;
    if (obs != exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame-level model: position within the frame decides every output
  task automatic modelEdge(input bit rst, input int pi, input int si);
    logic [3:0] e;
    int pe, se;
    if (!rst) begin
      mPos = 0; mP = 1; mS = 0; mH = 1; mClamp = 1'b0;
      e = 4'b0000;
      vcoQ.delete();
    end else if (mPos == mP - 1) begin
      pe = (pi < PMIN) ? PMIN : pi;
      se = (si > pe) ? pe : si;
      mClamp = (pi < PMIN) || (si > pe);
      mP = pe; mS = se; mH = pe / 2; mPos = 0;
      vcoQ.push_back(N * pe + se);
      e = {(mS > 0), 1'b1, 1'b1, mClamp};
    end else begin
      mPos++;
      e = {(mPos < mS), (mPos < mH), 1'b0, mClamp};
    end
    expQ.push_back(e);
  endtask

  task automatic observe(input bit rst);
    logic [3:0] e;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 0, 1);
    end else begin
      e = expQ.pop_front();
      checkOutput("mc", int'(mc), int'(e[3]));
      checkOutput("div_out", int'(div_out), int'(e[2]));
      checkOutput("load", int'(load), int'(e[1]));
      checkOutput("clamp", int'(clamp), int'(e[0]));
    end
    if (!rst) begin
      vcoValid = 1'b0;
      vcoAcc = 0;
    end else begin
      if (load) begin
        if (vcoValid) begin
          if (vcoQ.size() == 0) checkOutput("vco_queue_empty", 0, 1);
          else checkOutput("vco_per_frame", vcoAcc, vcoQ.pop_front());
        end
        vcoValid = 1'b1;
        vcoAcc = 0;
      end
      vcoAcc += N + int'(mc);
    end
  endtask

  task automatic applyStimulus(input bit rst, input int pi, input int si, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst_n = rst;
      Pi = pi[PW-1:0];
      Si = si[SW-1:0];
      modelEdge(rst, pi, si);
      @(posedge clk);
      #1;
      observe(rst);
    end
  endtask

  task automatic runUntilPos(input int target, input int pi, input int si);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      applyStimulus(1'b1, pi, si, 1);
      if (mPos == target) hit = 1'b1;
    end
    if (!hit) checkOutput("pos_timeout", mPos, target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got %0t, expected < 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] reset and nominal 20/5 frames");
    applyStimulus(1'b0, 20, 5, 3);
    applyStimulus(1'b1, 20, 5, 45);

    $display("[TB] ratio update to 13/0 mid-frame");
    runUntilPos(19, 20, 5);
    runUntilPos(6, 20, 5);
    applyStimulus(1'b1, 13, 0, 39);

    $display("[TB] clamping 1/3 then 4/7");
    runUntilPos(12, 13, 0);
    applyStimulus(1'b1, 1, 3, 6);
    applyStimulus(1'b1, 4, 7, 12);

    $display("[TB] maximum 31/7");
    applyStimulus(1'b1, 31, 7, 70);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 20, 5, 40);
    runUntilPos(9, 20, 5);
    applyStimulus(1'b0, 20, 5, 2);
    applyStimulus(1'b1, 20, 5, 45);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
